// File: rtl/taxi_eth_phy_rx_lock_mlane.sv
// rtl/taxi_eth_phy_rx_lock_mlane.sv - per-lane 64b/66b sync-header block lock with bitslip control
module taxi_eth_phy_rx_lock_mlane #(
  parameter int LANES               = 1,
  parameter int HDR_W               = 2,
  parameter int LOCK_CNT            = 64,
  parameter int WINDOW_CNT          = 64,
  parameter int UNLOCK_INVLD        = 16,
  parameter int BITSLIP_HIGH_CYCLES = 0,
  parameter int BITSLIP_LOW_CYCLES  = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LANES*HDR_W-1:0] serdes_rx_hdr,
  input  logic [LANES-1:0]       serdes_rx_hdr_valid,
  output logic [LANES-1:0]       serdes_rx_bitslip,
  output logic [LANES-1:0]       rx_block_lock,
  output logic                   rx_block_lock_all,
  output logic [LANES-1:0]       rx_invld_hdr,
  input  logic                   cfg_rx_enable
);

  localparam int MAX_CNT  = (LOCK_CNT > WINDOW_CNT) ? LOCK_CNT : WINDOW_CNT;
  localparam int CNT_W    = $clog2(MAX_CNT) + 1;
  localparam int SLIP_MAX = (BITSLIP_HIGH_CYCLES > BITSLIP_LOW_CYCLES) ?
                            BITSLIP_HIGH_CYCLES : BITSLIP_LOW_CYCLES;
  localparam int SLIP_W   = $clog2(SLIP_MAX + 1) + 1;
  localparam int LOW_LAST_I = (BITSLIP_LOW_CYCLES > 0) ? BITSLIP_LOW_CYCLES - 1 : 0;

  localparam logic [CNT_W-1:0]  LOCK_LAST   = CNT_W'(LOCK_CNT - 1);
  localparam logic [CNT_W-1:0]  WINDOW_LAST = CNT_W'(WINDOW_CNT - 1);
  localparam logic [CNT_W-1:0]  UNLOCK_LAST = CNT_W'(UNLOCK_INVLD - 1);
  localparam logic [SLIP_W-1:0] HIGH_LAST   = SLIP_W'(BITSLIP_HIGH_CYCLES);
  localparam logic [SLIP_W-1:0] LOW_LAST    = SLIP_W'(LOW_LAST_I);

  typedef enum logic [1:0] {
    ST_HUNT      = 2'd0,
    ST_SLIP_HIGH = 2'd1,
    ST_SLIP_WAIT = 2'd2,
    ST_LOCKED    = 2'd3
  } state_t;

  // Only a 2-bit sync header is meaningful for 64b/66b.
  if (HDR_W != 2) begin : g_hdr_w_check
    $error("taxi_eth_phy_rx_lock_mlane: HDR_W must be 2");
  end

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    state_t              state_q;
    logic [CNT_W-1:0]    sh_cnt_q;
    logic [CNT_W-1:0]    invld_cnt_q;
    logic [SLIP_W-1:0]   slip_cnt_q;
    logic                lock_q;
    logic                slip_q;
    logic                invld_q;
    logic [HDR_W-1:0]    hdr;
    logic                hdr_ok;
    logic                qual;

    assign hdr    = serdes_rx_hdr[n*HDR_W +: HDR_W];
    assign hdr_ok = (hdr == 2'b01) || (hdr == 2'b10);
    assign qual   = serdes_rx_hdr_valid[n];

    // Lane lock FSM: hunt for LOCK_CNT good headers, slip on a bad one, police error rate per window once locked.
    always_ff @(posedge clk) begin
      if (!rst_n || !cfg_rx_enable) begin
        state_q     <= ST_HUNT;
        sh_cnt_q    <= '0;
        invld_cnt_q <= '0;
        slip_cnt_q  <= '0;
        lock_q      <= 1'b0;
        slip_q      <= 1'b0;
        invld_q     <= 1'b0;
      end else begin
        invld_q <= 1'b0;
        case (state_q)
          ST_HUNT: begin
            if (qual) begin
              if (!hdr_ok) begin
                invld_q    <= 1'b1;
                slip_q     <= 1'b1;
                slip_cnt_q <= '0;
                sh_cnt_q   <= '0;
                state_q    <= ST_SLIP_HIGH;
              end else if (sh_cnt_q == LOCK_LAST) begin
                lock_q      <= 1'b1;
                sh_cnt_q    <= '0;
                invld_cnt_q <= '0;
                state_q     <= ST_LOCKED;
              end else begin
                sh_cnt_q <= sh_cnt_q + 1'b1;
              end
            end
          end
          ST_SLIP_HIGH: begin
            if (slip_cnt_q == HIGH_LAST) begin
              slip_q     <= 1'b0;
              slip_cnt_q <= '0;
              state_q    <= (BITSLIP_LOW_CYCLES == 0) ? ST_HUNT : ST_SLIP_WAIT;
            end else begin
              slip_cnt_q <= slip_cnt_q + 1'b1;
            end
          end
          ST_SLIP_WAIT: begin
            if (slip_cnt_q == LOW_LAST) begin
              slip_cnt_q <= '0;
              state_q    <= ST_HUNT;
            end else begin
              slip_cnt_q <= slip_cnt_q + 1'b1;
            end
          end
          ST_LOCKED: begin
            if (qual) begin
              if (!hdr_ok) invld_q <= 1'b1;
              if (!hdr_ok && invld_cnt_q == UNLOCK_LAST) begin
                // Unlock takes priority over a coincident window end.
                lock_q      <= 1'b0;
                slip_q      <= 1'b1;
                slip_cnt_q  <= '0;
                sh_cnt_q    <= '0;
                invld_cnt_q <= '0;
                state_q     <= ST_SLIP_HIGH;
              end else if (sh_cnt_q == WINDOW_LAST) begin
                sh_cnt_q    <= '0;
                invld_cnt_q <= '0;
              end else begin
                sh_cnt_q <= sh_cnt_q + 1'b1;
                if (!hdr_ok) invld_cnt_q <= invld_cnt_q + 1'b1;
              end
            end
          end
          default: state_q <= ST_HUNT;
        endcase
      end
    end

    assign serdes_rx_bitslip[n] = slip_q;
    assign rx_block_lock[n]     = lock_q;
    assign rx_invld_hdr[n]      = invld_q;
  end

  // Aggregate lock, one cycle behind the per-lane lock bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_block_lock_all <= 1'b0;
    end else begin
      rx_block_lock_all <= &rx_block_lock;
    end
  end

endmodule

// File: tb/tb_taxi_eth_phy_rx_lock_mlane.sv
// tb/tb_taxi_eth_phy_rx_lock_mlane.sv - randomized reference-model bench for the block lock engine
module tb_taxi_eth_phy_rx_lock_mlane;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [7:0] hdr_a = '0;
  logic [3:0] hv_a = '0;
  logic [3:0] slip_a, lock_a, invld_a;
  logic       all_a;
  logic [1:0] hdr_b = '0;
  logic [0:0] hv_b = '0;
  logic [0:0] slip_b, lock_b, invld_b;
  logic       all_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  taxi_eth_phy_rx_lock_mlane #(.LANES(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .serdes_rx_hdr(hdr_a), .serdes_rx_hdr_valid(hv_a),
    .serdes_rx_bitslip(slip_a), .rx_block_lock(lock_a), .rx_block_lock_all(all_a),
    .rx_invld_hdr(invld_a), .cfg_rx_enable(en)
  );

  taxi_eth_phy_rx_lock_mlane #(
    .LANES(1), .LOCK_CNT(8), .WINDOW_CNT(8), .UNLOCK_INVLD(3),
    .BITSLIP_HIGH_CYCLES(3), .BITSLIP_LOW_CYCLES(2)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .serdes_rx_hdr(hdr_b), .serdes_rx_hdr_valid(hv_b),
    .serdes_rx_bitslip(slip_b), .rx_block_lock(lock_b), .rx_block_lock_all(all_b),
    .rx_invld_hdr(invld_b), .cfg_rx_enable(en)
  );

  // Reference model: lanes 0..3 are DUT A, lane 4 is DUT B.
  int p_lock[5]   = '{64, 64, 64, 64, 8};
  int p_window[5] = '{64, 64, 64, 64, 8};
  int p_unlock[5] = '{16, 16, 16, 16, 3};
  int p_high[5]   = '{0, 0, 0, 0, 3};
  int p_low[5]    = '{7, 7, 7, 7, 2};
  bit m_locked[5];
  bit m_invld[5];
  int m_good[5], m_win[5], m_bad[5], m_blank[5];
  bit m_all_a, m_all_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic lane_clear(input int l);
    m_locked[l] = 0; m_invld[l] = 0;
    m_good[l] = 0; m_win[l] = 0; m_bad[l] = 0; m_blank[l] = 0;
  endtask

  task automatic start_slip(input int l);
    m_blank[l] = p_high[l] + 1 + p_low[l];
    m_good[l] = 0; m_win[l] = 0; m_bad[l] = 0;
  endtask

  task automatic lane_step(input int l, input logic [1:0] h, input logic v);
    bit bad;
    m_invld[l] = 0;
    if (m_blank[l] > 0) begin
      m_blank[l]--;
      return;
    end
    if (!v) return;
    bad = (h == 2'b00) || (h == 2'b11);
    if (bad) m_invld[l] = 1;
    if (!m_locked[l]) begin
      if (bad) start_slip(l);
      else begin
        m_good[l]++;
        if (m_good[l] == p_lock[l]) begin
          m_locked[l] = 1; m_good[l] = 0; m_win[l] = 0; m_bad[l] = 0;
        end
      end
    end else begin
      m_win[l]++;
      if (bad) m_bad[l]++;
      if (bad && m_bad[l] == p_unlock[l]) begin
        m_locked[l] = 0;
        start_slip(l);
      end else if (m_win[l] == p_window[l]) begin
        m_win[l] = 0; m_bad[l] = 0;
      end
    end
  endtask

  task automatic model_step();
    bit old_a, old_b;
    old_a = m_locked[0] & m_locked[1] & m_locked[2] & m_locked[3];
    old_b = m_locked[4];
    if (!rst_n) begin
      for (int l = 0; l < 5; l++) lane_clear(l);
      m_all_a = 0; m_all_b = 0;
      return;
    end
    m_all_a = old_a; m_all_b = old_b;
    for (int l = 0; l < 5; l++) begin
      if (!en) lane_clear(l);
      else if (l < 4) lane_step(l, hdr_a[l*2 +: 2], hv_a[l]);
      else lane_step(l, hdr_b, hv_b[0]);
    end
  endtask

  task automatic step();
    logic [3:0] e_slip, e_lock, e_invld;
    @(posedge clk);
    model_step();
    #1;
    for (int l = 0; l < 4; l++) begin
      e_slip[l]  = m_blank[l] > p_low[l];
      e_lock[l]  = m_locked[l];
      e_invld[l] = m_invld[l];
    end
    check("a_bitslip", slip_a, e_slip);
    check("a_lock", lock_a, e_lock);
    check("a_invld", invld_a, e_invld);
    check("a_lock_all", all_a, m_all_a);
    check("b_bitslip", slip_b, m_blank[4] > p_low[4]);
    check("b_lock", lock_b, m_locked[4]);
    check("b_invld", invld_b, m_invld[4]);
    check("b_lock_all", all_b, m_all_b);
  endtask

  function automatic logic [1:0] good_hdr();
    return ($urandom_range(1) != 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_hdr();
    return ($urandom_range(1) != 0) ? 2'b00 : 2'b11;
  endfunction

  task automatic all_good();
    for (int l = 0; l < 4; l++) hdr_a[l*2 +: 2] = good_hdr();
    hv_a = 4'hf;
    hdr_b = good_hdr();
    hv_b = 1'b1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    en = 1'b1;
    for (int i = 0; i < cycles; i++) step();
    rst_n = 1'b1;
  endtask

  int q;
  int err_pct[5];
  int rates[5] = '{0, 1, 3, 10, 50};

  initial begin
    // Reset state
    do_reset(3);
    check("rst_lock", lock_a, 4'h0);
    check("rst_slip", slip_a, 4'h0);
    check("rst_all", all_a, 1'b0);

    // Slip timing on lane 1 of A: one-cycle bitslip, then 7 ignored headers
    all_good();
    hdr_a[3:2] = 2'b11;
    step();
    check("slip_pulse", slip_a[1], 1'b1);
    check("slip_invld", invld_a[1], 1'b1);
    for (int i = 0; i < 8; i++) begin
      all_good();
      hdr_a[3:2] = 2'b00;
      step();
      check("slip_low", slip_a[1], 1'b0);
      check("slip_ignored", invld_a[1], 1'b0);
    end
    all_good();
    hdr_a[3:2] = 2'b00;
    step();
    check("hunt_resumed", slip_a[1], 1'b1);

    // Lock acquire
    do_reset(1);
    for (int i = 1; i <= 64; i++) begin
      all_good();
      step();
      if (i == 63) check("acq_63", lock_a, 4'h0);
    end
    check("acq_64", lock_a, 4'hf);

    // Unlock threshold on lane 0: 15 invalid in a window holds lock
    for (int i = 0; i < 64; i++) begin
      all_good();
      if (i < 15) hdr_a[1:0] = bad_hdr();
      step();
    end
    check("inv15_locked", lock_a[0], 1'b1);
    for (int i = 0; i < 16; i++) begin
      all_good();
      hdr_a[1:0] = bad_hdr();
      step();
    end
    check("inv16_unlock", lock_a[0], 1'b0);
    check("inv16_slip", slip_a[0], 1'b1);
    for (int i = 0; i < 72; i++) begin
      all_good();
      step();
    end
    check("relock", lock_a[0], 1'b1);
    // 15 invalid headers straddling a window boundary
    for (int i = 0; i < 71; i++) begin
      all_good();
      if (i >= 56) hdr_a[1:0] = bad_hdr();
      step();
    end
    check("straddle_locked", lock_a[0], 1'b1);

    // Gearbox stall: one qualified header in 33 cycles
    do_reset(1);
    q = 0;
    for (int cyc = 0; q < 64; cyc++) begin
      all_good();
      if (cyc % 33 != 0) begin
        hv_a = 4'h0; hv_b = 1'b0;
        for (int l = 0; l < 4; l++) hdr_a[l*2 +: 2] = 2'($urandom_range(3));
        hdr_b = 2'($urandom_range(3));
      end else q++;
      step();
      if (hv_a[0] && q == 63) check("gate_63", lock_a, 4'h0);
    end
    check("gate_64", lock_a, 4'hf);

    // Multi-lane: lane 2 fed only invalid headers
    do_reset(1);
    for (int i = 0; i < 200; i++) begin
      all_good();
      hdr_a[5:4] = bad_hdr();
      step();
    end
    check("ml_lock", lock_a, 4'b1011);
    check("ml_all", all_a, 1'b0);
    for (int i = 0; i < 100; i++) begin
      all_good();
      step();
    end
    check("ml_fixed_all", all_a, 1'b1);

    // Reset while DUT B is in its 4-cycle bitslip
    do_reset(1);
    all_good();
    hdr_b = 2'b11;
    step();
    check("b_slip_on", slip_b, 1'b1);
    all_good();
    step();
    rst_n = 1'b0;
    step();
    check("b_rst_slip", slip_b, 1'b0);
    rst_n = 1'b1;

    // Disable while locked, then relock
    do_reset(1);
    for (int i = 0; i < 64; i++) begin
      all_good();
      step();
    end
    check("dis_pre", lock_a, 4'hf);
    en = 1'b0;
    all_good();
    step();
    check("dis_lock", lock_a, 4'h0);
    en = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      all_good();
      step();
      if (i == 63) check("reen_63", lock_a, 4'h0);
    end
    check("reen_64", lock_a, 4'hf);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if (i % 400 == 0)
        for (int l = 0; l < 5; l++) err_pct[l] = rates[$urandom_range(4)];
      for (int l = 0; l < 4; l++) begin
        hdr_a[l*2 +: 2] = ($urandom_range(99) < err_pct[l]) ? bad_hdr() : good_hdr();
        hv_a[l] = $urandom_range(99) < 85;
      end
      hdr_b = ($urandom_range(99) < err_pct[4]) ? bad_hdr() : good_hdr();
      hv_b = 1'($urandom_range(99) < 85);
      en = ($urandom_range(499) != 0);
      rst_n = ($urandom_range(999) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
